output_vc_arbiter: RTL
======================

Name: output_vc_arbiter

Overview:
- Sequential, parametrised successor to the per-output-port combinational VC priority check.
- Each cycle, selects one of NUM_VC virtual channels feeding an output port and forwards its flit.
- Fair round-robin selection; per-VC downstream credit counters; wormhole packet locking (head to tail).
- Registered output.
- Sits between the input-VC buffers and the output link of each router port.

Parameters:
- NUM_VC, 4, number of virtual channels competing for this output port (2..16).
- FLIT_W, 32, flit width in bits.
- CREDIT_DEPTH, 4, downstream buffer slots per VC; initial and maximum credit count.
- VC_ID_W, 2, width of VC index; must equal clog2(NUM_VC).
- CNT_W, 3, credit counter width; must equal clog2(CREDIT_DEPTH+1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- vc_valid  input  NUM_VC  VC i has a flit at its buffer head.
- vc_is_head  input  NUM_VC  head-of-buffer flit of VC i is a head flit.
- vc_is_tail  input  NUM_VC  head-of-buffer flit of VC i is a tail flit (head+tail = single-flit packet).
- vc_flit  input  NUM_VC*FLIT_W  flit of VC i in bits [i*FLIT_W +: FLIT_W].
- credit_in  input  NUM_VC  one-cycle pulse; downstream freed one slot of VC i.
- vc_pop  output  NUM_VC  combinational one-hot grant; VC i buffer dequeues this cycle.
- flit_out  output  FLIT_W  registered granted flit.
- flit_valid  output  1  flit_out valid this cycle.
- flit_vc_id  output  VC_ID_W  VC index of flit_out.
- credit_err  output  1  sticky; credit_in received while that counter = CREDIT_DEPTH.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - all credit counters = CREDIT_DEPTH; rr_ptr = NUM_VC-1 (so VC0 has top priority first).
  - state = IDLE; lock_vc = 0.
  - flit_out = 0, flit_valid = 0, flit_vc_id = 0, credit_err = 0.
  - vc_pop = 0 while rst=1.
  - Reset mid-packet drops the lock. Upstream/downstream are reset together; no partial-packet recovery.
- Eligibility, IDLE: VC i eligible iff vc_valid[i] & vc_is_head[i] & (cnt[i] != 0). A non-head flit at a buffer head in IDLE is never granted.
- Eligibility, LOCKED: only lock_vc eligible, iff vc_valid & (cnt != 0). No head check. Other VCs stall; bubbles are allowed.
- Selection: round-robin over eligible VCs, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_VC. At most one grant per cycle.
- Grant on VC g (same cycle): vc_pop[g] = 1.
- Grant on VC g (next posedge):
  - flit_out = flit of g; flit_vc_id = g; flit_valid = 1.
  - cnt[g] decremented.
- No grant: flit_valid = 0 next cycle; flit_out and flit_vc_id hold their previous values.
- Latency: 1 cycle from grant to flit_valid. Throughput: 1 flit per cycle when credits are available.
- FSM:
  - IDLE -> LOCKED when granted flit is head & !tail; lock_vc = g.
  - IDLE stays IDLE when granted flit is head & tail.
  - LOCKED -> IDLE when the lock_vc flit granted is a tail.
- rr_ptr updates to g only when a tail flit (including single-flit) is granted. Fairness is per packet, not per flit.
- Credit counters, per VC per cycle:
  - cnt_next = cnt - grant_i + credit_in_i.
  - Simultaneous grant and credit on the same VC leaves cnt unchanged.
  - cnt = CREDIT_DEPTH with credit_in and no grant: cnt holds at CREDIT_DEPTH and credit_err is set. Never wraps.
  - cnt = 0: the VC is not eligible, so it never underflows.
- credit_err clears only on rst.

Decomposition:
- Shared constants in constants.v: `VC_NUM, `FLIT_SIZE, `VC_SIZE_default, plus new `CREDIT_DEPTH_default. Module parameters default from these.
- One natural sub-module: rr_arbiter.
  - Combinational, NUM_VC-wide.
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot grant, encoded index, any_grant.
  - Reused by the future switch allocator.
- Credit counters, FSM and output register live in output_vc_arbiter.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all vc_valid=0 -> flit_valid=0, vc_pop=0, and every counter reads 4 after 10 cycles.
- Round-robin of single-flit packets: VC0..3 all valid, head=tail=1, credits returned each cycle -> grants VC0,1,2,3,0,... and flit_vc_id sequence matches one cycle later.
- Wormhole lock: VC1 sends a 3-flit packet (H,B,T) while VC2 holds a head -> VC1 granted three consecutive cycles, VC2 granted on the 4th; VC1 body flit with vc_is_head=0 is accepted only while LOCKED.
- Credit exhaustion: VC0 sends 6 single flits, no credit_in -> exactly 4 grants, then stall; one credit_in pulse -> exactly one more grant the following cycle.
- Simultaneous grant and credit: VC3 with cnt=2 is granted in the same cycle credit_in[3]=1 -> cnt stays 2. Extra credit_in at cnt=4 -> credit_err=1, cnt remains 4.
- Reset mid-packet: rst asserted after the head of a 4-flit packet on VC2 -> state IDLE, flit_valid=0; after rst, a head on VC0 is granted first.

Source files
------------

// File: rtl/output_vc_arbiter_pkg.sv
// Shared defaults and FSM encoding for output-port VC arbitration.
// Module parameters default from these values.
package output_vc_arbiter_pkg;

  localparam int VC_NUM               = 4;
  localparam int FLIT_SIZE            = 32;
  localparam int VC_SIZE_DEFAULT      = 2;
  localparam int CREDIT_DEPTH_DEFAULT = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/output_vc_arbiter_rr.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... modulo NUM_VC.
// Zero latency; no backpressure, the caller qualifies the request vector.
module rr_arbiter #(
  parameter int NUM_VC = 4,
  parameter int ID_W   = 2
) (
  input  logic [NUM_VC-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [NUM_VC-1:0] gnt,
  output logic [ID_W-1:0]   idx,
  output logic              any_grant
);

  always_comb begin
    logic [ID_W-1:0] c;
    gnt       = '0;
    idx       = '0;
    any_grant = 1'b0;
    c         = '0;
    for (int k = 1; k <= NUM_VC; k++) begin
      c = ID_W'((int'(ptr) + k) % NUM_VC);
      if (!any_grant && req[c]) begin
        gnt[c]    = 1'b1;
        idx       = c;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_vc_arbiter.sv
// Per-output-port VC arbiter: round-robin, credit-gated, wormhole-locked; flit registered 1 cycle after vc_pop.
// A VC with zero credits or a non-head flit (while idle) is simply not granted; bubbles are allowed.
module output_vc_arbiter
  import output_vc_arbiter_pkg::*;
#(
  parameter int NUM_VC       = VC_NUM,
  parameter int FLIT_W       = FLIT_SIZE,
  parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEFAULT,
  parameter int VC_ID_W      = VC_SIZE_DEFAULT,
  parameter int CNT_W        = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_VC-1:0]        vc_valid,
  input  logic [NUM_VC-1:0]        vc_is_head,
  input  logic [NUM_VC-1:0]        vc_is_tail,
  input  logic [NUM_VC*FLIT_W-1:0] vc_flit,
  input  logic [NUM_VC-1:0]        credit_in,
  output logic [NUM_VC-1:0]        vc_pop,
  output logic [FLIT_W-1:0]        flit_out,
  output logic                     flit_valid,
  output logic [VC_ID_W-1:0]       flit_vc_id,
  output logic                     credit_err
);

  logic [NUM_VC-1:0][CNT_W-1:0] cnt;
  logic [VC_ID_W-1:0]           rr_ptr;
  logic [VC_ID_W-1:0]           lock_vc;
  state_t                       state;

  logic [NUM_VC-1:0]            elig;
  logic [NUM_VC-1:0]            req;
  logic [NUM_VC-1:0]            gnt;
  logic [VC_ID_W-1:0]           gnt_idx;
  logic                         gnt_any;
  logic [FLIT_W-1:0]            flit_arr [NUM_VC];

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      flit_arr[i] = vc_flit[i*FLIT_W +: FLIT_W];
      if (state == IDLE)
        elig[i] = vc_valid[i] & vc_is_head[i] & (cnt[i] != '0);
      else
        elig[i] = (VC_ID_W'(i) == lock_vc) & vc_valid[i] & (cnt[i] != '0);
    end
  end

  assign req    = rst ? '0 : elig;
  assign vc_pop = gnt;

  rr_arbiter #(
    .NUM_VC (NUM_VC),
    .ID_W   (VC_ID_W)
  ) u_rr (
    .req       (req),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .idx       (gnt_idx),
    .any_grant (gnt_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VC; i++) cnt[i] <= CNT_W'(CREDIT_DEPTH);
      rr_ptr     <= VC_ID_W'(NUM_VC - 1);
      lock_vc    <= '0;
      state      <= IDLE;
      flit_out   <= '0;
      flit_valid <= 1'b0;
      flit_vc_id <= '0;
      credit_err <= 1'b0;
    end else begin
      // Grant and credit in the same cycle cancel; an overflowing credit is dropped and flagged.
      for (int i = 0; i < NUM_VC; i++) begin
        if (gnt[i] && !credit_in[i]) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end else if (!gnt[i] && credit_in[i]) begin
          if (cnt[i] == CNT_W'(CREDIT_DEPTH)) credit_err <= 1'b1;
          else cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end

      flit_valid <= gnt_any;
      if (gnt_any) begin
        flit_out   <= flit_arr[gnt_idx];
        flit_vc_id <= gnt_idx;
      end

      case (state)
        IDLE: begin
          if (gnt_any && !vc_is_tail[gnt_idx]) begin
            state   <= LOCKED;
            lock_vc <= gnt_idx;
          end
        end
        LOCKED: begin
          if (gnt_any && vc_is_tail[gnt_idx]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Pointer only advances at packet boundaries so fairness is per packet.
      if (gnt_any && vc_is_tail[gnt_idx]) rr_ptr <= gnt_idx;
    end
  end

endmodule
